// File: rtl/alu_slice_seq_controller_pkg.sv
// rtl/alu_slice_seq_controller_pkg.sv - shared types, select encodings and opcode fields for the slice controller
package alu_slice_seq_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        Q_NONE  = 2'd0,
        Q_SHR   = 2'd1,
        Q_LOADF = 2'd2,
        Q_SHL   = 2'd3
    } q_sel_t;

    typedef enum logic [1:0] {
        R_D    = 2'd0,
        R_A    = 2'd1,
        R_ZERO = 2'd2
    } r_sel_t;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_Q    = 2'd2,
        S_ZERO = 2'd3
    } s_sel_t;

    // Register-file write source: shifted right, straight F, shifted left
    localparam logic [1:0] RF_SHR   = 2'd0;
    localparam logic [1:0] RF_LOADF = 2'd1;
    localparam logic [1:0] RF_SHL   = 2'd2;

    localparam int FIELD_W  = 3;
    localparam int DEST_LSB = 6;
    localparam int FUNC_LSB = 3;
    localparam int SRC_LSB  = 0;

    function automatic r_sel_t decode_r(input logic [2:0] src);
        case (src)
            3'd0, 3'd1:       decode_r = R_A;
            3'd2, 3'd3, 3'd4: decode_r = R_ZERO;
            default:          decode_r = R_D;
        endcase
    endfunction

    function automatic s_sel_t decode_s(input logic [2:0] src);
        case (src)
            3'd0, 3'd2, 3'd6: decode_s = S_Q;
            3'd1, 3'd3:       decode_s = S_B;
            3'd4, 3'd5:       decode_s = S_A;
            default:          decode_s = S_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/alu_slice_seq_controller_slice_flag_gen.sv
// rtl/alu_slice_seq_controller_slice_flag_gen.sv - combinational status flags from the ALU slice outputs
module slice_flag_gen #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] p,
    output logic             g_lo,
    output logic             p_lo,
    output logic             ovr,
    output logic             z
);

    // Overflow is the parity of the two most significant carries
    localparam logic [WIDTH-1:0] CARRY_TOP = WIDTH'(3) << (WIDTH - 2);

    assign g_lo = ~c[WIDTH-1];
    assign p_lo = ~&p;
    assign ovr  = ^(c & CARRY_TOP);
    assign z    = ~|f;

endmodule

// File: rtl/alu_slice_seq_controller.sv
// rtl/alu_slice_seq_controller.sv - Am2901-style slice sequencer: instruction capture, decode, shift repeat and flags
module alu_slice_seq_controller
    import alu_slice_seq_controller_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [8:0]           i,
    input  logic [ADDR_W-1:0]    a,
    input  logic [ADDR_W-1:0]    b,
    input  logic [CNT_W-1:0]     rpt,
    input  logic [WIDTH-1:0]     f,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     p,
    output logic [2**ADDR_W-1:0] select_a_hi,
    output logic [2**ADDR_W-1:0] select_b_hi,
    output logic                 reg_wr,
    output logic                 reg_wr_n,
    output logic [1:0]           select_regfile,
    output logic [1:0]           select_regfile_n,
    output logic [1:0]           select_q_reg,
    output logic [1:0]           select_q_reg_n,
    output logic [1:0]           select_ALU_r,
    output logic [1:0]           select_ALU_r_n,
    output logic [1:0]           select_ALU_s,
    output logic [1:0]           select_ALU_s_n,
    output logic                 select_y,
    output logic                 select_y_n,
    output logic                 inv_r,
    output logic                 inv_s,
    output logic                 sel_f0,
    output logic                 sel_f1,
    output logic                 not_sel_f0,
    output logic                 not_sel_f1,
    output logic                 shl_en,
    output logic                 shr_en,
    output logic                 g_lo,
    output logic                 p_lo,
    output logic                 ovr,
    output logic                 z,
    output logic                 busy,
    output logic                 done
);

    localparam int NREG = 2**ADDR_W;

    state_t             state;
    logic [8:0]         ir_i;
    logic [ADDR_W-1:0]  ir_a;
    logic [ADDR_W-1:0]  ir_b;
    logic [CNT_W-1:0]   ir_rpt;
    logic [CNT_W-1:0]   cnt;

    logic [2:0] dest;
    logic [2:0] func;
    logic [2:0] src;
    logic       wants_repeat;
    logic       last_cycle;
    logic       g_lo_c;
    logic       p_lo_c;
    logic       ovr_c;
    logic       z_c;

    assign dest = ir_i[DEST_LSB +: FIELD_W];
    assign func = ir_i[FUNC_LSB +: FIELD_W];
    assign src  = ir_i[SRC_LSB +: FIELD_W];

    // Only shifting destinations honour the repeat count
    assign wants_repeat = ir_i[8] && (ir_rpt != '0);
    assign last_cycle   = ((state == ST_EXEC) && !wants_repeat)
                       || ((state == ST_REPEAT) && (cnt == CNT_W'(1)));

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);

    slice_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .f    (f),
        .c    (c),
        .p    (p),
        .g_lo (g_lo_c),
        .p_lo (p_lo_c),
        .ovr  (ovr_c),
        .z    (z_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ir_i   <= '0;
            ir_a   <= '0;
            ir_b   <= '0;
            ir_rpt <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            g_lo   <= 1'b1;
            p_lo   <= 1'b1;
            ovr    <= 1'b0;
            z      <= 1'b1;
        end else begin
            done <= last_cycle;
            if (last_cycle) begin
                g_lo <= g_lo_c;
                p_lo <= p_lo_c;
                ovr  <= ovr_c;
                z    <= z_c;
            end
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir_i   <= i;
                        ir_a   <= a;
                        ir_b   <= b;
                        ir_rpt <= rpt;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wants_repeat) begin
                        cnt   <= ir_rpt;
                        state <= ST_REPEAT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REPEAT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_wr         = 1'b0;
        select_regfile = RF_SHR;
        select_q_reg   = Q_NONE;
        select_ALU_r   = R_D;
        select_ALU_s   = S_A;
        select_y       = 1'b1;
        inv_r          = 1'b0;
        inv_s          = 1'b0;
        sel_f0         = 1'b0;
        sel_f1         = 1'b0;
        shl_en         = 1'b0;
        shr_en         = 1'b0;
        if (state != ST_IDLE) begin
            reg_wr   = dest[2] | dest[1];
            select_y = (dest != 3'b010);
            shl_en   = dest[2] & dest[1];
            shr_en   = dest[2] & ~dest[1];
            case (dest[2:1])
                2'b10:   select_regfile = RF_SHR;
                2'b11:   select_regfile = RF_SHL;
                default: select_regfile = RF_LOADF;
            endcase
            case (dest)
                3'b100:  select_q_reg = Q_SHR;
                3'b110:  select_q_reg = Q_SHL;
                3'b000:  select_q_reg = Q_LOADF;
                default: select_q_reg = Q_NONE;
            endcase
            if (state == ST_REPEAT) begin
                // Repeat cycles pass B through the shifter; Q only shifts alongside RAM
                select_ALU_r = R_ZERO;
                select_ALU_s = S_B;
                if (dest[0]) begin
                    select_q_reg = Q_NONE;
                end
            end else begin
                select_ALU_r = decode_r(src);
                select_ALU_s = decode_s(src);
                inv_r        = ~func[1] & func[0];
                inv_s        = (~func[2] & func[1] & ~func[0]) | (func[2] & func[1] & func[0]);
                sel_f0       = (func[1] & func[0]) | (func[2] & func[1]);
                sel_f1       = func[2];
            end
        end
    end

    assign select_a_hi = {{(NREG-1){1'b0}}, 1'b1} << ir_a;
    assign select_b_hi = {{(NREG-1){1'b0}}, 1'b1} << ir_b;

    assign reg_wr_n         = ~reg_wr;
    assign select_regfile_n = ~select_regfile;
    assign select_q_reg_n   = ~select_q_reg;
    assign select_ALU_r_n   = ~select_ALU_r;
    assign select_ALU_s_n   = ~select_ALU_s;
    assign select_y_n       = ~select_y;
    assign not_sel_f0       = ~sel_f0;
    assign not_sel_f1       = ~sel_f1;

endmodule
